// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetches words over a req/ack handshake and
// queues {pc, instr} pairs in a 2-entry buffer toward decode.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   pc_in / target            current PC in, next PC out (combinational)
//   imem_req/addr/ack/rdata   instruction memory handshake
//   instr_valid/instr/pc      buffer head toward decode
//   dec_ready                 decode accepts head
//   branch_valid/target       redirect request
module instr_fetch_unit #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic [ADDR_W-1:0]  target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               dec_ready,
   input  logic               branch_valid,
   input  logic [ADDR_W-1:0]  branch_target
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DRAIN,
      S_FULL
   } state_t;

   state_t              state;
   logic [1:0]          count;
   logic [1:0]          count_nxt;
   logic [ADDR_W-1:0]   pending;
   logic [ADDR_W-1:0]   pc1;
   logic [INSTR_W-1:0]  ins1;
   logic                push;
   logic                pop;
   logic                flush;

   assign imem_req    = (state == S_REQ) || (state == S_DRAIN);
   assign imem_addr   = pc_in;
   assign instr_valid = (count != 2'd0);

   // Branch empties the buffer in every state; outside S_REQ/S_FULL
   // the buffer is already empty, so this only matters there.
   assign flush = branch_valid;
   assign pop   = instr_valid && dec_ready;
   assign push  = (state == S_REQ) && imem_ack && !branch_valid;

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = 2'd0;
      else if (push && !pop)
         count_nxt = count + 2'd1;
      else if (pop && !push)
         count_nxt = count - 2'd1;
   end

   always_comb begin
      target = pc_in;
      unique case (state)
         S_IDLE: begin
            if (branch_valid)
               target = branch_target;
         end
         S_REQ: begin
            if (imem_ack)
               target = branch_valid ? branch_target
                                     : pc_in + ADDR_W'(1);
         end
         S_DRAIN: begin
            if (imem_ack)
               target = branch_valid ? branch_target : pending;
         end
         S_FULL: begin
            if (branch_valid)
               target = branch_target;
         end
         default: target = pc_in;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         count    <= 2'd0;
         pending  <= '0;
         instr    <= '0;
         instr_pc <= '0;
         pc1      <= '0;
         ins1     <= '0;
      end else begin
         unique case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (imem_ack) begin
                  if (branch_valid)
                     state <= S_REQ;
                  else if (count_nxt == 2'd2)
                     state <= S_FULL;
                  else
                     state <= S_REQ;
               end else if (branch_valid) begin
                  // Outstanding request must complete before redirect.
                  pending <= branch_target;
                  state   <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (imem_ack)
                  state <= S_REQ;
               else if (branch_valid)
                  pending <= branch_target;
            end
            S_FULL: begin
               if (branch_valid || pop)
                  state <= S_REQ;
            end
            default: state <= S_IDLE;
         endcase

         count <= count_nxt;
         if (!flush) begin
            if (pop) begin
               if (count == 2'd2) begin
                  instr    <= ins1;
                  instr_pc <= pc1;
                  if (push) begin
                     ins1 <= imem_rdata;
                     pc1  <= pc_in;
                  end
               end else if (push) begin
                  instr    <= imem_rdata;
                  instr_pc <= pc_in;
               end
            end else if (push) begin
               if (count == 2'd0) begin
                  instr    <= imem_rdata;
                  instr_pc <= pc_in;
               end else begin
                  ins1 <= imem_rdata;
                  pc1  <= pc_in;
               end
            end
         end
      end
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly downstream of the program counter. It takes the current `pc_out` as `pc_in`, fetches instruction words from instruction memory over a req/ack handshake, and queues them with their PCs in a 2-entry buffer toward decode. It drives the PC's `target` input every cycle, which gives it sequential advance, hold and branch redirect with flush.

## Interface
- `ADDR_W`, default 16: PC / instruction-memory word-address width.
- `INSTR_W`, default 16: instruction word width.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pc_in`  in  ADDR_W: current PC (program counter `pc_out`).
- `target`  out  ADDR_W: next-PC value, combinational, fed to the program counter `target`.
- `imem_req`  out  1: fetch request; address is `imem_addr`.
- `imem_addr`  out  ADDR_W: equals `pc_in`.
- `imem_ack`  in  1: one-cycle pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  INSTR_W: fetched instruction word.
- `instr_valid`  out  1: buffer head valid (count != 0).
- `instr`  out  INSTR_W: buffer head instruction.
- `instr_pc`  out  ADDR_W: PC of buffer head.
- `dec_ready`  in  1: decode accepts the head; a pop occurs when `instr_valid && dec_ready`.
- `branch_valid`  in  1: redirect request, one cycle.
- `branch_target`  in  ADDR_W: redirect address.

## Operation
- Buffer: 2-entry FIFO of {pc, instr} with count 0..2.
  - Push and pop can happen in the same cycle.
  - The head is registered.
- At most one memory request is outstanding.
- `imem_req` depends only on state, never on `dec_ready`.
- Once `imem_req` is raised, it and `imem_addr` stay stable until `imem_ack`.
- `imem_ack` is ignored while `imem_req` = 0.
- States:
  - S_IDLE (reset state): `imem_req` = 0, `target` = `pc_in`. Next state is S_REQ.
  - S_REQ: `imem_req` = 1. Behaviour depends on the `imem_ack` / `branch_valid` combination:
    - ack, no branch: push {`pc_in`, `imem_rdata`}; `target` = `pc_in` + 1. Next state is S_FULL if the resulting count is 2, else S_REQ.
    - ack with branch: discard the data and flush the buffer; `target` = `branch_target`; next state S_REQ.
    - branch, no ack: flush the buffer; `pending` <= `branch_target`; `target` = `pc_in`; next state S_DRAIN.
    - neither: `target` = `pc_in`; remain in S_REQ.
  - S_DRAIN: `imem_req` = 1; returned data is always discarded. `target` = `pc_in` until `imem_ack`.
    - On ack: `target` = `branch_target` if `branch_valid`, else `pending`; next state S_REQ.
    - On branch without ack: `pending` <= `branch_target` (newest branch wins).
    - The buffer stays empty.
  - S_FULL: `imem_req` = 0, `target` = `pc_in`.
    - On pop: next state S_REQ.
    - On `branch_valid`: flush; `target` = `branch_target`; next state S_REQ (flush takes priority over pop).
- Flush: count <= 0 at the edge; a pop in the same cycle is ignored.
- Arithmetic: `pc_in` + 1 is computed modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
- A `branch_valid` in S_IDLE is honoured: `target` = `branch_target`.

## Timing
- Reset values:
  - state S_IDLE, count 0, `instr_valid` 0, `instr` 0, `instr_pc` 0, `pending` 0, `imem_req` 0.
  - `target` = `pc_in`, which is 0 from the PC under reset.
- The first `imem_req` is high in the first cycle after `rst` deasserts.
- With zero-wait memory (ack in the same cycle as req), throughput is 1 instruction per cycle.
  - Request at address A in cycle N, then at A+1 in cycle N+1.
  - `instr_valid` rises in cycle N+1 with `instr_pc` = A.
- Fetch latency: an instruction acked in cycle N is visible at the head in cycle N+1 if the buffer was empty.
- Redirect: the PC holds `branch_target` one cycle after the redirect is accepted (in S_REQ, S_FULL, or with ack in S_DRAIN). The first request to it is issued in that cycle.
- A request is raised only when count < 2 at entry to S_REQ, so an ack always finds space.
- `rst` mid-request: immediate return to S_IDLE with buffer cleared. A late `imem_ack` arriving while `imem_req` = 0 is ignored.

## Test plan
- Reset, zero-wait memory, `dec_ready` = 1, `imem_rdata` = 0x1000 + addr -> `instr_pc` 0,1,2,3 on consecutive cycles with `instr` 0x1000..0x1003; no gaps.
- `dec_ready` = 0 -> exactly 2 entries (pc 0, 1) buffered, `imem_req` drops in S_FULL, PC holds at 2. Raise `dec_ready` -> pc 2 is fetched the cycle after the pop.
- Memory with 3-cycle ack latency, `branch_valid` with target 0x0040 in the second wait cycle -> `imem_addr` stays stable until ack, data is discarded, the next request is at 0x0040, and no stale `instr_valid` appears.
- `branch_valid` (target 0x0100) in the same cycle as `imem_ack` and a pop with 2 entries -> buffer empty next cycle; next `instr_pc` is 0x0100.
- PC at 0xFFFF, ack -> `target` = 0x0000 and the next fetch is at address 0.
- Assert `rst` while a request is outstanding, then pulse `imem_ack` during reset -> all outputs are at reset values and fetching restarts at 0.
